// File: rtl/reg_bank.sv
// reg_bank: parametrised control-register store with a sel/wr/ready request
// handshake, per-byte write strobes, WAIT_CYCLES wait states per access and a
// registered one-cycle completion pulse (ack with rdata/err).
//
// Optional feature: define REG_BANK_ADDR_CHECK_EN to flag accesses with
// addr >= DEPTH by raising err in the ack cycle. Out-of-range writes are
// always dropped and out-of-range reads always return 0; without the macro err
// is tied low.
module reg_bank #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 256,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0,
  parameter int unsigned           WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_sel,
  input  logic                    i_wr,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  output logic                    o_ready,
  output logic                    o_ack,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_err
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  // Counter load value on acceptance; counting reaches 0 on the last wait cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD =
      CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    StIdle,
    StWait
  } state_t;

  // State and storage
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Completion data held across the wait states
  logic [DATA_WIDTH-1:0] r_pend_rdata;
  logic                  r_pend_err;

  // Registered completion outputs
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  // Request decode
  logic                  w_accept;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_cpl_rdata;
  logic                  w_cpl_err;

  // Completion pulse for the current cycle
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_done_rdata;
  logic                  w_done_err;

  assign o_ready    = (r_state == StIdle);
  assign w_accept   = i_sel && (r_state == StIdle);
  assign w_in_range = ({1'b0, i_addr} < DEPTH_LIM);
  assign w_idx      = i_addr[IDX_W-1:0];

  // Read value sampled at the acceptance edge; out-of-range reads give 0.
  assign w_rd_word   = w_in_range ? r_mem[w_idx] : '0;
  assign w_cpl_rdata = i_wr ? '0 : w_rd_word;

`ifdef REG_BANK_ADDR_CHECK_EN
  assign w_cpl_err = ~w_in_range;
`else
  assign w_cpl_err = 1'b0;
`endif

  // Register array: reset to RESET_VAL, byte-masked update on accepted writes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= RESET_VAL;
      end
    end else if (w_accept && i_wr && w_in_range) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (i_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // FSM state and wait counter register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, wait countdown and which completion fires this cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_done       = 1'b0;
    w_done_rdata = '0;
    w_done_err   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            // No wait states: complete straight from the acceptance edge.
            w_done       = 1'b1;
            w_done_rdata = w_cpl_rdata;
            w_done_err   = w_cpl_err;
          end else begin
            w_state_nxt = StWait;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_state_nxt  = StIdle;
          w_done       = 1'b1;
          w_done_rdata = r_pend_rdata;
          w_done_err   = r_pend_err;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Hold the result computed at acceptance until the wait states expire.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pend_rdata <= '0;
      r_pend_err   <= 1'b0;
    end else if (w_accept) begin
      r_pend_rdata <= w_cpl_rdata;
      r_pend_err   <= w_cpl_err;
    end
  end

  // Completion outputs: a single-cycle pulse, zero otherwise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_ack   <= w_done;
      r_rdata <= w_done_rdata;
      r_err   <= w_done_err;
    end
  end

  assign o_ack   = r_ack;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: two instances (k=0: WAIT_CYCLES=3, DEPTH=200,
// RESET_VAL=32'h1234_5678; k=1: WAIT_CYCLES=0, DEPTH=256, RESET_VAL=0), a
// transaction-level model checked against the outputs every cycle, and
// directed vectors with literal expectations.
module tb_reg_bank;

`ifdef REG_BANK_ADDR_CHECK_EN
  localparam bit AddrChk = 1'b1;
`else
  localparam bit AddrChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  sel;
  logic [1:0]  wr;
  logic [7:0]  addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic [1:0]  ready;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [31:0] rdata [2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  reg_bank #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .DEPTH      (200),
    .RESET_VAL  (32'h1234_5678),
    .WAIT_CYCLES(3)
  ) u_dut_w3 (
    .clk    (clk),
    .rstn   (rstn),
    .i_sel  (sel[0]),
    .i_wr   (wr[0]),
    .i_addr (addr[0]),
    .i_wdata(wdata[0]),
    .i_wstrb(wstrb[0]),
    .o_ready(ready[0]),
    .o_ack  (ack[0]),
    .o_rdata(rdata[0]),
    .o_err  (err[0])
  );

  reg_bank #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .DEPTH      (256),
    .RESET_VAL  (32'h0000_0000),
    .WAIT_CYCLES(0)
  ) u_dut_w0 (
    .clk    (clk),
    .rstn   (rstn),
    .i_sel  (sel[1]),
    .i_wr   (wr[1]),
    .i_addr (addr[1]),
    .i_wdata(wdata[1]),
    .i_wstrb(wstrb[1]),
    .o_ready(ready[1]),
    .o_ack  (ack[1]),
    .o_rdata(rdata[1]),
    .o_err  (err[1])
  );

  function automatic int wait_of(int k);
    return (k == 0) ? 3 : 0;
  endfunction

  function automatic int depth_of(int k);
    return (k == 0) ? 200 : 256;
  endfunction

  function automatic logic [31:0] rv_of(int k);
    return (k == 0) ? 32'h1234_5678 : 32'h0000_0000;
  endfunction

  // ---------------- transaction model ----------------
  // Each accepted request occupies the bank for W cycles after acceptance;
  // its result is visible in the cycle after the W-th following edge.
  logic [31:0] m_mem [2][256];
  int          m_busy [2];
  logic [31:0] m_pend_rd [2];
  logic        m_pend_err [2];
  logic [1:0]  e_ready;
  logic [1:0]  e_ack;
  logic [1:0]  e_err;
  logic [31:0] e_rdata [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        for (int a = 0; a < 256; a++) m_mem[k][a] = rv_of(k);
        m_busy[k]  = 0;
        e_ack[k]   = 1'b0;
        e_rdata[k] = '0;
        e_err[k]   = 1'b0;
      end else begin
        e_ack[k]   = 1'b0;
        e_rdata[k] = '0;
        e_err[k]   = 1'b0;
        if (m_busy[k] > 0) begin
          m_busy[k] = m_busy[k] - 1;
          if (m_busy[k] == 0) begin
            e_ack[k]   = 1'b1;
            e_rdata[k] = m_pend_rd[k];
            e_err[k]   = m_pend_err[k];
          end
        end else if (sel[k]) begin
          bit          inr;
          logic [31:0] rd;
          bit          er;
          inr = int'(addr[k]) < depth_of(k);
          rd  = '0;
          if (wr[k]) begin
            if (inr) begin
              for (int b = 0; b < 4; b++)
                if (wstrb[k][b]) m_mem[k][addr[k]][8*b +: 8] = wdata[k][8*b +: 8];
            end
          end else begin
            rd = inr ? m_mem[k][addr[k]] : 32'h0;
          end
          er = AddrChk && !inr;
          if (wait_of(k) == 0) begin
            e_ack[k]   = 1'b1;
            e_rdata[k] = rd;
            e_err[k]   = er;
          end else begin
            m_busy[k]     = wait_of(k);
            m_pend_rd[k]  = rd;
            m_pend_err[k] = er;
          end
        end
      end
      e_ready[k] = (m_busy[k] == 0);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ready[k] !== e_ready[k] || ack[k] !== e_ack[k] ||
            rdata[k] !== e_rdata[k] || err[k] !== e_err[k]) begin
          n_errors++;
          $display("FAIL model_cmp inst%0d t=%0t: got ready=%b ack=%b rdata=%h err=%b, want ready=%b ack=%b rdata=%h err=%b",
                   k, $time, ready[k], ack[k], rdata[k], err[k],
                   e_ready[k], e_ack[k], e_rdata[k], e_err[k]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // Issue one request on instance k and wait (bounded) for its completion.
  task automatic req(input int k, input bit w, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    sel[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d; wstrb[k] = s;
    n = 0;
    while (ready[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'b0, ready[k]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    sel[k] = 1'b0;
    n = 0;
    while (ack[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", {31'b0, ack[k]}, 32'd1);
    rd = rdata[k];
    er = err[k];
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          acks;

    rstn = 1'b0;
    sel  = '0;
    wr   = '0;
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready0", {31'b0, ready[0]}, 32'd1);
    chk("reset_ack0", {31'b0, ack[0]}, 32'd0);
    chk("reset_rdata0", rdata[0], 32'h0);
    rstn   = 1'b1;
    chk_en = 1'b1;

    // Reset values read back from the first, last and an inner address.
    req(0, 1'b0, 8'd0, 32'h0, 4'h0, rd, er);
    chk("rst_rd_a0", rd, 32'h1234_5678);
    chk("rst_rd_a0_err", {31'b0, er}, 32'd0);
    req(0, 1'b0, 8'd1, 32'h0, 4'h0, rd, er);
    chk("rst_rd_a1", rd, 32'h1234_5678);
    req(0, 1'b0, 8'd199, 32'h0, 4'h0, rd, er);
    chk("rst_rd_a199", rd, 32'h1234_5678);
    chk("rst_rd_a199_err", {31'b0, er}, 32'd0);

    // Byte-strobe merge on both instances.
    for (int k = 0; k < 2; k++) begin
      req(k, 1'b1, 8'd5, 32'hDEAD_BEEF, 4'b1111, rd, er);
      chk("wr_full_rdata", rd, 32'h0);
      req(k, 1'b1, 8'd5, 32'h0000_00AA, 4'b0001, rd, er);
      req(k, 1'b0, 8'd5, 32'h0, 4'h0, rd, er);
      chk("strb_merge", rd, 32'hDEAD_BEAA);
      req(k, 1'b1, 8'd5, 32'hFFFF_FFFF, 4'b0000, rd, er);
      req(k, 1'b0, 8'd5, 32'h0, 4'h0, rd, er);
      chk("strb_none", rd, 32'hDEAD_BEAA);
    end

    // Wait-state timing with sel toggling during the wait (instance 0, W=3).
    @(negedge clk);
    sel[0] = 1'b1; wr[0] = 1'b0; addr[0] = 8'd1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_ready_low", {31'b0, ready[0]}, 32'd0);
      chk("wait_no_ack", {31'b0, ack[0]}, 32'd0);
      sel[0] = (i == 1);
    end
    @(negedge clk);
    chk("wait_done_ready", {31'b0, ready[0]}, 32'd1);
    chk("wait_done_ack", {31'b0, ack[0]}, 32'd1);
    chk("wait_done_rdata", rdata[0], 32'h1234_5678);
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[0] === 1'b1) acks++;
    end
    chk("wait_extra_acks", 32'(acks), 32'd0);

    // Back-to-back writes then reads at full rate (instance 1, W=0).
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_ready", {31'b0, ready[1]}, 32'd1);
        chk("b2b_ack", {31'b0, ack[1]}, 32'd1);
        chk("b2b_rdata", rdata[1], (i - 1 < 4) ? 32'h0 : 32'hA0A0_0000 + 32'(i - 5));
      end
      if (i < 8) begin
        sel[1] = 1'b1; wr[1] = (i < 4); addr[1] = 8'(i % 4);
        wdata[1] = 32'hA0A0_0000 + 32'(i); wstrb[1] = 4'hF;
      end else begin
        sel[1] = 1'b0;
      end
    end

    // Reset during the second wait cycle of a write to addr 7 (instance 0).
    @(negedge clk);
    sel[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'd7; wdata[0] = 32'h55AA_55AA; wstrb[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    sel[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_ready", {31'b0, ready[0]}, 32'd1);
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[0] === 1'b1) acks++;
    end
    chk("midrst_no_ack", 32'(acks), 32'd0);
    req(0, 1'b0, 8'd7, 32'h0, 4'h0, rd, er);
    chk("midrst_rd_a7", rd, 32'h1234_5678);

    // Out-of-range accesses on the DEPTH=200 instance.
    req(0, 1'b1, 8'd210, 32'hCAFE_F00D, 4'hF, rd, er);
    chk("oor_wr_err", {31'b0, er}, {31'b0, AddrChk});
    req(0, 1'b0, 8'd210, 32'h0, 4'h0, rd, er);
    chk("oor_rd_rdata", rd, 32'h0);
    chk("oor_rd_err", {31'b0, er}, {31'b0, AddrChk});
    req(0, 1'b0, 8'd10, 32'h0, 4'h0, rd, er);
    chk("oor_alias10", rd, 32'h1234_5678);
    req(0, 1'b0, 8'd82, 32'h0, 4'h0, rd, er);
    chk("oor_alias82", rd, 32'h1234_5678);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
